branch_target_lut: RTL and testbench
====================================

Name: branch_target_lut

Overview:
- Programmable, banked branch-target table. Maps a jump pointer to an absolute instruction address for the fetch stage.
- Generalises the fixed pointer-to-address table: width, depth and bank count are parameters. Entries are written at run time instead of hard-coded.
- Each program owns one bank; the active bank is selected by a register.
- Adds valid tracking, miss reporting, a self-clearing init sequence, and a registered lookup with write bypass.

Parameters:
PTR_W, 4, pointer width; entries per bank = 2**PTR_W
ADDR_W, 10, absolute target address width
BANKS, 4, number of banks (one per program); power of two, >=2
BANK_W, $clog2(BANKS), bank index width (derived, not overridden)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
ClearReq  input  1  request full table clear (honoured in READY only)
BankWe  input  1  load BankIn into active-bank register
BankIn  input  BANK_W  new active bank
WrEn  input  1  write one entry
WrBank  input  BANK_W  bank for write
WrPtr  input  PTR_W  entry index for write
WrAddr  input  ADDR_W  target address to store
LookupReq  input  1  lookup request
LutPointer  input  PTR_W  entry index in active bank
absaddress  output  ADDR_W  looked-up target (registered)
LookupValid  output  1  one-cycle pulse: absaddress/LookupMiss valid
LookupMiss  output  1  entry was not valid; absaddress forced 0
Busy  output  1  table clearing
WrErr  output  1  one-cycle pulse: write dropped
ActiveBank  output  BANK_W  current active bank

Behaviour:
- Clk is the only clock. Reset is asynchronous and active-high.
- Reset values:
  - absaddress=0, LookupValid=0, LookupMiss=0, WrErr=0, ActiveBank=0.
  - All BANKS*2**PTR_W valid bits=0.
  - State=CLEAR, clear counter=0, Busy=1.
- Storage:
  - Data array has no reset (RAM-inferable).
  - Valid bits are flops with async reset.
- FSM, two states:
  - CLEAR: each cycle writes 0 to data[counter] and increments the counter. After writing the last entry (counter = BANKS*2**PTR_W-1) -> READY, counter wraps to 0. Duration is exactly BANKS*2**PTR_W cycles (64 at defaults).
  - READY: normal operation. ClearReq=1 -> CLEAR at the next edge; all valid bits clear on that same edge.
  - ClearReq during CLEAR is ignored; the counter does not restart.
- Busy = (state==CLEAR), registered.
- Writes:
  - In READY, WrEn=1 writes data[WrBank][WrPtr]=WrAddr and sets its valid bit.
  - In CLEAR, WrEn=1 is dropped and WrErr pulses high for one cycle.
  - WrEn and ClearReq in the same READY cycle: clear wins, write dropped, WrErr=1.
- Bank register:
  - BankWe=1 loads BankIn at the edge, in any state.
  - A lookup in the same cycle uses the old bank.
- Lookup timing:
  - LookupReq sampled at edge N. At edge N+1, LookupValid=1 for exactly one cycle.
  - If valid[ActiveBank][LutPointer]: absaddress=data, LookupMiss=0.
  - Otherwise: absaddress=0, LookupMiss=1.
  - In CLEAR, every lookup returns a miss.
  - Back-to-back requests give back-to-back valid pulses.
  - With no request, LookupValid=0 and absaddress/LookupMiss hold their last value.
- Write bypass: if WrEn is accepted in the same cycle as LookupReq, with WrBank==ActiveBank(old) and WrPtr==LutPointer, the response is WrAddr, LookupMiss=0.
- Reset mid-operation (any state) returns immediately to the reset values. A pending lookup response is lost.
- No arithmetic beyond the counter. Counter width = BANK_W+PTR_W; bank = counter MSBs, pointer = counter LSBs.

Decomposition:
- Shared package branch_lut_pkg holds:
  - defaults PTR_W_DEF=4, ADDR_W_DEF=10, BANKS_DEF=4
  - typedef enum logic {CLEAR, READY} lut_state_t
  - typedef for target address (logic [ADDR_W-1:0]).
- One natural sub-module: lut_bank_ram. Single write port, one combinational read port, no reset, flat index {bank,ptr}.
- FSM, valid bits, bypass and output registers stay in the top level.

Test Plan:
- Reset, hold Reset=0 -> Busy=1 for exactly 64 cycles, then 0. Lookup ptr 3 -> LookupValid one cycle later with LookupMiss=1, absaddress=0.
- After init: write bank0/ptr1=23, then lookup ptr1 next cycle -> absaddress=23, LookupMiss=0, LookupValid width 1 cycle.
- Same-cycle write bank0/ptr5=110 with LookupReq ptr5 -> response 110, no miss. Same case with WrBank=1 -> miss.
- Write bank2/ptr0=100, BankWe=1 BankIn=2 together with lookup ptr0 -> miss (old bank 0). Next lookup ptr0 -> 100; ActiveBank=2.
- Write during CLEAR, and WrEn with ClearReq in READY -> WrErr pulses 1 cycle, entry stays invalid. ClearReq -> Busy 64 cycles, prior entries miss afterwards.
- Assert Reset mid-CLEAR and on a LookupReq edge -> all outputs 0 immediately, no LookupValid pulse, clear restarts from count 0.

Source files
------------

// File: rtl/branch_lut_pkg.sv
// Shared definitions for the banked branch-target table.
// Holds the default geometry, the controller state encoding and the
// target-address type used by the fetch-side consumers.
package branch_lut_pkg;

  localparam int PTR_W_DEF  = 4;
  localparam int ADDR_W_DEF = 10;
  localparam int BANKS_DEF  = 4;

  // CLEAR: sweeping zeros through the data array; READY: normal service.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } lut_state_t;

  // Absolute target address at the default width.
  typedef logic [ADDR_W_DEF-1:0] lut_addr_t;

endpackage : branch_lut_pkg

// File: rtl/lut_bank_ram.sv
// Flat storage for all banks of the branch-target table.
// One synchronous write port and one combinational read port; no reset so
// the array can map onto distributed RAM. Index is {bank, ptr}.
// Ports:
//   clk   - write clock
//   we    - write enable
//   widx  - write index {bank, ptr}
//   wdata - write data
//   ridx  - read index {bank, ptr}
//   rdata - read data (combinational)
module lut_bank_ram #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [(1<<IDX_W)-1:0];

  // Single write port into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  assign rdata = mem_r[ridx];

endmodule : lut_bank_ram

// File: rtl/branch_target_lut.sv
// Programmable, banked branch-target table for the fetch stage.
// Maps a jump pointer in the active bank to an absolute instruction address.
// After reset (or on ClearReq) the controller sweeps zeros through every entry
// while Busy is high; writes arriving then are dropped and flagged on WrErr.
// Lookups are registered with a one-cycle response and bypass a same-cycle
// accepted write to the same entry.
// Ports:
//   Clk, Reset            - clock, async active-high reset
//   ClearReq              - request a full clear (honoured in READY only)
//   BankWe, BankIn        - load a new active bank
//   WrEn, WrBank, WrPtr,
//   WrAddr                - entry write
//   LookupReq, LutPointer - lookup in the active bank
//   absaddress            - registered lookup result
//   LookupValid           - one-cycle pulse, result valid
//   LookupMiss            - entry invalid, absaddress forced to 0
//   Busy                  - table is clearing
//   WrErr                 - one-cycle pulse, write dropped
//   ActiveBank            - current active bank
module branch_target_lut
  import branch_lut_pkg::*;
#(
  parameter int  PTR_W  = PTR_W_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  BANKS  = BANKS_DEF,
  localparam int BANK_W = $clog2(BANKS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClearReq,
  input  logic              BankWe,
  input  logic [BANK_W-1:0] BankIn,
  input  logic              WrEn,
  input  logic [BANK_W-1:0] WrBank,
  input  logic [PTR_W-1:0]  WrPtr,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic              LookupReq,
  input  logic [PTR_W-1:0]  LutPointer,
  output logic [ADDR_W-1:0] absaddress,
  output logic              LookupValid,
  output logic              LookupMiss,
  output logic              Busy,
  output logic              WrErr,
  output logic [BANK_W-1:0] ActiveBank
);

  localparam int CNT_W   = BANK_W + PTR_W;
  localparam int ENTRIES = 1 << CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  lut_state_t          state_r;
  lut_state_t          state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ENTRIES-1:0]  valid_r;
  logic [BANK_W-1:0]   bank_r;
  logic [ADDR_W-1:0]   absaddress_r;
  logic                lookup_valid_r;
  logic                lookup_miss_r;
  logic                busy_r;
  logic                wr_err_r;

  logic                ready_s;
  logic                wr_acc_s;
  logic [CNT_W-1:0]    wr_idx_s;
  logic [CNT_W-1:0]    rd_idx_s;
  logic                ram_we_s;
  logic [CNT_W-1:0]    ram_widx_s;
  logic [ADDR_W-1:0]   ram_wdata_s;
  logic [ADDR_W-1:0]   rd_data_s;
  logic                hit_s;
  logic                bypass_s;

  assign ready_s  = (state_r == READY);
  // A clear request in the same cycle takes priority over the write.
  assign wr_acc_s = ready_s & WrEn & ~ClearReq;
  assign wr_idx_s = {WrBank, WrPtr};
  // Lookups use the bank held before any same-cycle BankWe.
  assign rd_idx_s = {bank_r, LutPointer};
  // Valid bits are all zero while clearing, so this also forces misses then.
  assign hit_s    = ready_s & valid_r[rd_idx_s];
  assign bypass_s = wr_acc_s & (WrBank == bank_r) & (WrPtr == LutPointer);

  // Next-state logic for the clear/ready controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      READY: begin
        if (ClearReq) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = READY;
        end
      end
      default: state_nxt_s = CLEAR;
    endcase
  end

  // State register, clear counter and Busy flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == CLEAR);
      // Full-width counter wraps to zero after the last entry.
      if (state_r == CLEAR) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // RAM write port: the clear sweep owns it while clearing.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_widx_s  = '0;
    ram_wdata_s = '0;
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_widx_s  = cnt_r;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = wr_acc_s;
      ram_widx_s  = wr_idx_s;
      ram_wdata_s = WrAddr;
    end
  end

  lut_bank_ram #(
    .IDX_W  (CNT_W),
    .DATA_W (ADDR_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we_s),
    .widx  (ram_widx_s),
    .wdata (ram_wdata_s),
    .ridx  (rd_idx_s),
    .rdata (rd_data_s)
  );

  // Per-entry valid bits: wiped on entry to CLEAR, set by accepted writes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_r <= '0;
    end else if (ready_s && ClearReq) begin
      valid_r <= '0;
    end else if (wr_acc_s) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Active bank register and dropped-write flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bank_r   <= '0;
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= WrEn & ~wr_acc_s;
      if (BankWe) begin
        bank_r <= BankIn;
      end
    end
  end

  // Registered lookup response; result and miss hold when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      absaddress_r   <= '0;
      lookup_valid_r <= 1'b0;
      lookup_miss_r  <= 1'b0;
    end else begin
      lookup_valid_r <= LookupReq;
      if (LookupReq) begin
        if (bypass_s) begin
          absaddress_r  <= WrAddr;
          lookup_miss_r <= 1'b0;
        end else if (hit_s) begin
          absaddress_r  <= rd_data_s;
          lookup_miss_r <= 1'b0;
        end else begin
          absaddress_r  <= '0;
          lookup_miss_r <= 1'b1;
        end
      end
    end
  end

  assign absaddress  = absaddress_r;
  assign LookupValid = lookup_valid_r;
  assign LookupMiss  = lookup_miss_r;
  assign Busy        = busy_r;
  assign WrErr       = wr_err_r;
  assign ActiveBank  = bank_r;

endmodule : branch_target_lut

// File: tb/tb_branch_target_lut.sv
// Self-checking bench for branch_target_lut at default geometry.
// A behavioural model of the table predicts each lookup response when the
// request is driven (pushed to a scoreboard queue) and predicts Busy, WrErr
// and ActiveBank; the DUT is compared every cycle after the clock edge.
module tb_branch_target_lut;

  logic       clk;
  logic       rst;
  logic       clear_req;
  logic       bank_we;
  logic [1:0] bank_in;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [3:0] wr_ptr;
  logic [9:0] wr_addr;
  logic       lookup_req;
  logic [3:0] lut_ptr;
  logic [9:0] absaddress;
  logic       lookup_valid;
  logic       lookup_miss;
  logic       busy;
  logic       wr_err;
  logic [1:0] active_bank;

  int n_vec;
  int n_err;

  // model state
  logic [9:0]  m_data [64];
  bit          m_valid [64];
  bit          m_clear;
  int          m_cnt;
  logic [1:0]  m_bank;
  bit          m_wrerr;
  logic [10:0] sb_q [$];
  logic [10:0] last_resp;

  branch_target_lut dut (
    .Clk        (clk),
    .Reset      (rst),
    .ClearReq   (clear_req),
    .BankWe     (bank_we),
    .BankIn     (bank_in),
    .WrEn       (wr_en),
    .WrBank     (wr_bank),
    .WrPtr      (wr_ptr),
    .WrAddr     (wr_addr),
    .LookupReq  (lookup_req),
    .LutPointer (lut_ptr),
    .absaddress (absaddress),
    .LookupValid(lookup_valid),
    .LookupMiss (lookup_miss),
    .Busy       (busy),
    .WrErr      (wr_err),
    .ActiveBank (active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    clear_req  = 1'b0;
    bank_we    = 1'b0;
    bank_in    = 2'd0;
    wr_en      = 1'b0;
    wr_bank    = 2'd0;
    wr_ptr     = 4'd0;
    wr_addr    = 10'd0;
    lookup_req = 1'b0;
    lut_ptr    = 4'd0;
  endtask

  task automatic model_reset();
    m_clear   = 1'b1;
    m_cnt     = 0;
    m_bank    = 2'd0;
    m_wrerr   = 1'b0;
    last_resp = 11'd0;
    sb_q.delete();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Advance the model by one cycle with the current inputs, clock, then compare.
  task automatic step();
    logic [5:0]  idx;
    logic [5:0]  widx;
    bit          acc;
    logic [10:0] e;
    if (!rst) begin
      acc  = !m_clear && wr_en && !clear_req;
      widx = {wr_bank, wr_ptr};
      if (lookup_req) begin
        idx = {m_bank, lut_ptr};
        if (acc && wr_bank == m_bank && wr_ptr == lut_ptr) sb_q.push_back({1'b0, wr_addr});
        else if (!m_clear && m_valid[idx]) sb_q.push_back({1'b0, m_data[idx]});
        else sb_q.push_back({1'b1, 10'd0});
      end
      m_wrerr = wr_en && !acc;
      if (m_clear) begin
        m_cnt++;
        if (m_cnt == 64) begin
          m_clear = 1'b0;
          m_cnt   = 0;
        end
      end else if (clear_req) begin
        m_clear = 1'b1;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      end
      if (acc) begin
        m_valid[widx] = 1'b1;
        m_data[widx]  = wr_addr;
      end
      if (bank_we) m_bank = bank_in;
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    check_val("busy", {31'd0, busy}, {31'd0, m_clear});
    check_val("wrerr", {31'd0, wr_err}, {31'd0, m_wrerr});
    check_val("bank", {30'd0, active_bank}, {30'd0, m_bank});
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      last_resp = e;
      check_val("lv", {31'd0, lookup_valid}, 32'd1);
    end else begin
      check_val("lv_idle", {31'd0, lookup_valid}, 32'd0);
    end
    check_val("addr", {22'd0, absaddress}, {22'd0, last_resp[9:0]});
    check_val("miss", {31'd0, lookup_miss}, {31'd0, last_resp[10]});
  endtask

  // Reset has just been raised mid-cycle: outputs must already be at reset values.
  task automatic check_reset_now();
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd1);
    check_val("rst_addr", {22'd0, absaddress}, 32'd0);
    check_val("rst_lv", {31'd0, lookup_valid}, 32'd0);
    check_val("rst_miss", {31'd0, lookup_miss}, 32'd0);
    check_val("rst_wrerr", {31'd0, wr_err}, 32'd0);
    check_val("rst_bank", {30'd0, active_bank}, 32'd0);
    model_reset();
  endtask

  task automatic do_write(input logic [1:0] b, input logic [3:0] p, input logic [9:0] a);
    wr_en = 1'b1; wr_bank = b; wr_ptr = p; wr_addr = a;
  endtask

  task automatic do_lookup(input logic [3:0] p);
    lookup_req = 1'b1; lut_ptr = p;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    // init sweep: Busy high for exactly 64 cycles
    repeat (64) step();
    // empty table -> miss
    do_lookup(4'd3); step(); idle(); step();
    // write then lookup
    do_write(2'd0, 4'd1, 10'd23); step(); idle();
    do_lookup(4'd1); step(); idle(); step();
    // same-cycle bypass, then different bank -> miss
    do_write(2'd0, 4'd5, 10'd110); do_lookup(4'd5); step(); idle();
    do_write(2'd1, 4'd6, 10'd50); do_lookup(4'd6); step(); idle(); step();
    do_lookup(4'd5); step(); idle();
    // bank switch uses old bank for the same-cycle lookup
    do_write(2'd2, 4'd0, 10'd100); step(); idle();
    bank_we = 1'b1; bank_in = 2'd2; do_lookup(4'd0); step(); idle();
    do_lookup(4'd0); step(); idle(); step();
    // back-to-back lookups
    do_lookup(4'd0); step(); do_lookup(4'd1); step(); idle(); step();
    // write together with clear request is dropped
    clear_req = 1'b1; do_write(2'd2, 4'd7, 10'd9); step(); idle();
    // write and ignored clear request while clearing, lookup while clearing
    do_write(2'd2, 4'd8, 10'd11); clear_req = 1'b1; step(); idle();
    do_lookup(4'd0); step(); idle();
    repeat (64) step();
    do_lookup(4'd0); step(); do_lookup(4'd7); step(); do_lookup(4'd8); step(); idle(); step();
    // random traffic in normal operation
    for (int i = 0; i < 300; i++) begin
      idle();
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_bank    = 2'($urandom_range(0, 3));
      wr_ptr     = 4'($urandom_range(0, 15));
      wr_addr    = 10'($urandom_range(0, 1023));
      lookup_req = ($urandom_range(0, 1) == 1);
      lut_ptr    = 4'($urandom_range(0, 15));
      bank_we    = ($urandom_range(0, 9) == 0);
      bank_in    = 2'($urandom_range(0, 3));
      clear_req  = ($urandom_range(0, 149) == 0);
      step();
    end
    idle();
    repeat (70) step();
    // reset in the middle of a clear sweep; sweep restarts from zero
    clear_req = 1'b1; step(); idle();
    repeat (10) step();
    rst = 1'b1;
    check_reset_now();
    step();
    rst = 1'b0;
    repeat (64) step();
    // reset on a lookup edge after a valid response was shown
    do_write(2'd0, 4'd3, 10'd300); step(); idle();
    do_lookup(4'd3); step();
    rst = 1'b1;
    check_reset_now();
    step();
    rst = 1'b0; idle();
    step(); step();
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_branch_target_lut
